// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling.
// Emits a one-cycle rcv pulse for a good frame or frame_err for a low stop bit.
`default_nettype none

module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            rcv_q, rcv_d;
  logic            ferr_q, ferr_d;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rcv_q   <= rcv_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rcv_d   = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Half-bit wait lands the later samples in the middle of each bit cell.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            rcv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign rcv       = rcv_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into two receivers (BAUDRATE 104 and 16); a scoreboard
// queue per receiver holds expected pulses, popped by a negedge monitor.
`default_nettype none

module tb_uart_rx;

  localparam int B104 = 104;
  localparam int B16  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx104 = 1'b1;
  logic rx16  = 1'b1;
  logic [7:0] data104, data16;
  logic rcv104, rcv16, ferr104, ferr16, busy104, busy16;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int nb;
  bit ok;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t q104[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.BAUDRATE(B104)) u_rx104 (
    .clk(clk), .rst(rst), .rx(rx104), .data(data104),
    .rcv(rcv104), .frame_err(ferr104), .busy(busy104)
  );

  uart_rx #(.BAUDRATE(B16)) u_rx16 (
    .clk(clk), .rst(rst), .rx(rx16), .data(data16),
    .rcv(rcv16), .frame_err(ferr16), .busy(busy16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic score(input string n, input bit has, input exp_t e,
                       input logic r, input logic f, input logic [7:0] d);
    tests++;
    if (!has) begin
      fails++;
      $display("FAIL %s spurious pulse at cycle %0d: rcv=%0b frame_err=%0b, expected no pulse",
               n, cyc, r, f);
    end else if ((r && f) || (f != e.is_err) || (!e.is_err && d !== e.d) || (cyc != e.at)) begin
      fails++;
      $display("FAIL %s event: rcv=%0b frame_err=%0b data=%h cycle=%0d, expected %s data=%h cycle=%0d",
               n, r, f, d, cyc, e.is_err ? "frame_err" : "rcv", e.d, e.at);
    end
  endtask

  // Monitor: every output pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    bit   has;
    if (!rst) begin
      if (rcv104 || ferr104) begin
        has = (q104.size() > 0);
        if (has) e = q104.pop_front();
        score("b104", has, e, rcv104, ferr104, data104);
      end
      if (rcv16 || ferr16) begin
        has = (q16.size() > 0);
        if (has) e = q16.pop_front();
        score("b16", has, e, rcv16, ferr16, data16);
      end
    end
  end

  // Drives one 8N1 frame starting now (posedge+1); line left at the stop value.
  // Receiver pulse lands 2 sync cycles + half bit + 9 bits + 1 registered cycle later.
  task automatic tx(input bit sel16, input logic [7:0] b, input bit stop_v,
                    input int period, input bit expect_evt);
    logic [9:0] fr;
    int         bd;
    exp_t       e;
    fr = {stop_v, b, 1'b0};
    bd = sel16 ? B16 : B104;
    if (expect_evt) begin
      e.is_err = !stop_v;
      e.d      = b;
      e.at     = cyc + 2 + bd / 2 + 9 * bd + 1;
      if (sel16) q16.push_back(e);
      else       q104.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (sel16) rx16 = fr[i];
      else       rx104 = fr[i];
      repeat (period) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_data16", data16, 8'h00);
    check("reset_data104", data104, 8'h00);
    check("reset_pulses", {rcv16, ferr16, rcv104, ferr104}, 4'b0000);
    check("reset_busy", {busy16, busy104}, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", {busy16, busy104}, 2'b00);

    tx(1'b0, 8'h55, 1'b1, 104, 1'b1);
    tx(1'b0, 8'hC6, 1'b1, 100, 1'b1);
    tx(1'b0, 8'hC6, 1'b1, 108, 1'b1);
    check("skew_data104", data104, 8'hC6);

    tx(1'b1, 8'hA3, 1'b1, 16, 1'b1);
    tx(1'b1, 8'h0F, 1'b1, 16, 1'b1);
    check("b2b_data16", data16, 8'h0F);

    // 3-cycle low glitch: START sees a high line at its half-bit sample.
    rx16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx16 = 1'b1;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy16) nb++;
    end
    @(posedge clk);
    #1;
    check("glitch_busy_cycles", nb, 8);
    check("glitch_data_hold", data16, 8'h0F);

    tx(1'b1, 8'h3C, 1'b0, 16, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy16) ok = 1'b0;
    end
    check("break_busy_held", ok, 1'b1);
    @(posedge clk);
    #1;
    rx16 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("break_released_busy", busy16, 1'b0);
    check("ferr_data_hold", data16, 8'h0F);

    fork
      tx(1'b1, 8'hFF, 1'b1, 16, 1'b0);
      begin
        repeat (88) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy16, 1'b0);
        check("abort_data", data16, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    tx(1'b1, 8'h81, 1'b1, 16, 1'b1);
    check("post_reset_data16", data16, 8'h81);

    for (int i = 0; i < 500 && (q16.size() + q104.size()) > 0; i++) @(posedge clk);
    check("scoreboard_drained", q16.size() + q104.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BAUDRATE, default 104, system clock cycles per serial bit (115200 baud at 12 MHz); legal range 4..65535.
REQ-002 Ports, one per line:
  clk        input   1  system clock; all state updates on rising edge
  rst        input   1  asynchronous, active-high reset
  rx         input   1  serial line from pin, asynchronous to clk, idle high
  data       output  8  last correctly received byte
  rcv        output  1  one-cycle pulse: new byte valid on data
  frame_err  output  1  one-cycle pulse: stop bit sampled low
  busy       output  1  high while a frame is being received
REQ-003 The block SHALL use one clock (clk) and SHALL reset asynchronously on rst high.

Function
REQ-004 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-005 rx SHALL pass through a 2-flop synchronizer reset to 1; all logic SHALL use the synchronized value rx_s only.
REQ-006 A bit-timing counter of width $clog2(BAUDRATE) SHALL be integrated; it runs only outside IDLE and is held at 0 in IDLE.
REQ-007 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-008 IDLE: on the first cycle with rx_s==0 (call it T0), go to START and load the counter for a half-bit wait of BAUDRATE/2 cycles (integer division).
REQ-009 START: at T0+BAUDRATE/2 sample rx_s; if 0, go to DATA with bit index 0; if 1 (glitch), go to IDLE with no output pulse.
REQ-010 DATA: bit i (0..7) SHALL be sampled at T0+BAUDRATE/2+(i+1)*BAUDRATE and shifted into a shift register, LSB first; after bit 7, go to STOP.
REQ-011 STOP: sample at T0+BAUDRATE/2+9*BAUDRATE.
REQ-012 Stop bit 1: on the next cycle, load data from the shift register, pulse rcv for exactly one cycle, and go to IDLE.
REQ-013 Stop bit 0: on the next cycle, pulse frame_err for exactly one cycle, leave data unchanged, and go to WAIT_IDLE.
REQ-014 WAIT_IDLE: remain until rx_s==1 (break handling), then go to IDLE; no new start bit is accepted before that.
REQ-015 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-016 rcv and frame_err SHALL never be high in the same cycle.
REQ-017 data SHALL change only in the cycle rcv is high and SHALL hold its value otherwise.
REQ-018 The counter SHALL wrap from BAUDRATE-1 to 0 at each bit boundary with no overflow; it SHALL be reloaded on every entry to START.
REQ-019 Back-to-back frames: a start edge seen in IDLE in the cycle after rcv SHALL be accepted with no lost cycles beyond REQ-008 timing.
REQ-020 rx activity while busy SHALL NOT restart the frame; sampling occurs only at the instants in REQ-009..011.

Reset
REQ-021 While rst is high: state=IDLE, counter=0, shift register=0, data=8'h00, rcv=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-022 rst asserted mid-frame SHALL abort the frame immediately with no rcv/frame_err pulse.
REQ-023 After rst deasserts, the first falling edge of rx_s SHALL start a new frame.

Verification
REQ-024 BAUDRATE=104, send 0x55 at exact bit timing -> exactly one rcv pulse with data=0x55, frame_err=0, rcv at T0+989 (52+9*104+1).
REQ-025 BAUDRATE=16, send 0xA3 then 0x0F back-to-back (zero idle bits) -> two rcv pulses, data=0xA3 then 0x0F, 160 cycles apart.
REQ-026 BAUDRATE=16, rx low glitch of 3 cycles -> state returns to IDLE at T0+8, no rcv/frame_err, busy high for 8 cycles only.
REQ-027 BAUDRATE=16, send 0x3C with stop bit=0, rx held low 40 more cycles -> one frame_err pulse, data keeps previous value, busy stays high until rx returns to 1.
REQ-028 BAUDRATE=16, assert rst during bit 4 of 0xFF, release, send 0x81 -> no pulse for the aborted frame, then rcv with data=0x81.
REQ-029 BAUDRATE=104, transmitter bit period skewed +/-4% (100 and 108 cycles) sending 0xC6 -> data=0xC6 received correctly in both cases.
